// File: rtl/sysid_ext.sv
// System identification block: constant ID/version words, scratch register,
// free-running uptime counter with HI snapshot, capability word and user IDs.
module sysid_ext #(
    parameter logic [31:0] SYSTEM_ID    = 32'h4D49_4F5D,
    parameter logic [31:0] TIMESTAMP    = 32'h2F35_2BDF,
    parameter logic [31:0] VERSION      = 32'h0001_0000,
    parameter int          NUM_USER     = 4,
    parameter logic [32*((NUM_USER > 0) ? NUM_USER : 1)-1:0] USER_WORDS = '0,
    parameter int          READ_LATENCY = 1,
    parameter int          TICK_DIV     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    // Handshake: read and write are one-cycle strobes that are always accepted
    // (no waitrequest); every accepted read returns exactly one readdatavalid
    // pulse READ_LATENCY cycles later, in request order. A read that coincides
    // with a write is dropped and never answered.

    localparam logic [3:0]  ADDR_SYSID   = 4'd0;
    localparam logic [3:0]  ADDR_TSTAMP  = 4'd1;
    localparam logic [3:0]  ADDR_VERSION = 4'd2;
    localparam logic [3:0]  ADDR_SCRATCH = 4'd3;
    localparam logic [3:0]  ADDR_UP_LO   = 4'd4;
    localparam logic [3:0]  ADDR_UP_HI   = 4'd5;
    localparam logic [3:0]  ADDR_CAPS    = 4'd6;
    localparam logic [15:0] PRESCALE_MAX = 16'(TICK_DIV - 1);

    logic [31:0] scratch;
    logic [63:0] uptime;
    logic [15:0] prescaler;
    logic [31:0] hi_snap;
    logic        wr_err;

    logic        accept_rd;
    logic        tick;
    logic        err_set;
    logic        err_clr;
    logic [31:0] caps;
    logic [31:0] rd_mux;

    logic [31:0]             pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_vld;

    assign accept_rd = read & ~write;
    assign tick      = (prescaler == PRESCALE_MAX);
    assign caps      = {wr_err, 25'd0, 2'(READ_LATENCY), 4'(NUM_USER)};

    assign err_set = write & (((address != ADDR_SCRATCH) && (address != ADDR_CAPS)) | read);
    assign err_clr = write & (address == ADDR_CAPS) & writedata[31] & byteenable[3];

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_SYSID:   rd_mux = SYSTEM_ID;
            ADDR_TSTAMP:  rd_mux = TIMESTAMP;
            ADDR_VERSION: rd_mux = VERSION;
            ADDR_SCRATCH: rd_mux = scratch;
            ADDR_UP_LO:   rd_mux = uptime[31:0];
            ADDR_UP_HI:   rd_mux = hi_snap;
            ADDR_CAPS:    rd_mux = caps;
            default:      rd_mux = '0;
        endcase
        // User words live at 8.. and anything past NUM_USER reads as zero.
        for (int k = 0; k < NUM_USER; k++) begin
            if (address == 4'(8 + k)) begin
                rd_mux = USER_WORDS[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scratch   <= '0;
            uptime    <= '0;
            prescaler <= '0;
            hi_snap   <= '0;
            wr_err    <= 1'b0;
        end else begin
            if (tick) begin
                prescaler <= '0;
                uptime    <= uptime + 64'd1;
            end else begin
                prescaler <= prescaler + 16'd1;
            end

            if (write && (address == ADDR_SCRATCH)) begin
                for (int i = 0; i < 4; i++) begin
                    if (byteenable[i]) begin
                        scratch[8*i +: 8] <= writedata[8*i +: 8];
                    end
                end
            end

            // The snapshot captures the same counter value whose low half is read.
            if (accept_rd && (address == ADDR_UP_LO)) begin
                hi_snap <= uptime[63:32];
            end

            if (err_clr) begin
                wr_err <= 1'b0;
            end else if (err_set) begin
                wr_err <= 1'b1;
            end
        end
    end

    // Read data is captured at acceptance and then only shifted, so responses
    // reflect state at the request cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= accept_rd;
            pipe_data[0] <= accept_rd ? rd_mux : 32'd0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign readdata      = pipe_data[READ_LATENCY-1];
    assign readdatavalid = pipe_vld[READ_LATENCY-1];

endmodule
